// File: rtl/sram_defs.sv
// Shared definitions for the external SRAM controller.
// State encoding plus bus widths used by the MEM stage.
package sram_defs;

  localparam int REGISTER_LEN = 32;
  localparam int SRAM_DATA_LEN = 16;
  localparam int DEF_SRAM_ADDR_WIDTH = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Sequences 32-bit loads/stores as two 16-bit SRAM half cycles.
// Strobes are registered from the next state so pins never glitch.
module sram_controller
  import sram_defs::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [REGISTER_LEN-1:0]    address,
  input  logic [REGISTER_LEN-1:0]    write_data,
  output logic [REGISTER_LEN-1:0]    read_data,
  output logic                       ready,
  inout  wire  [SRAM_DATA_LEN-1:0]   sram_dq,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic                       sram_oe_n,
  output logic                       sram_ce_n,
  output logic                       sram_ub_n,
  output logic                       sram_lb_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int IW = SRAM_ADDR_WIDTH - 1;
  localparam logic [CW-1:0] CMAX = CW'(WAIT_CYCLES);

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            cnt_nx;
  logic                     wr_q;
  logic [IW-1:0]            idx_q;
  logic [REGISTER_LEN-1:0]  wdata_q;
  logic                     dq_oe_q;
  logic [SRAM_DATA_LEN-1:0] dq_out_q;
  logic [IW-1:0]            idx_in;
  logic                     req;
  logic                     unused_addr;

  assign idx_in = address[SRAM_ADDR_WIDTH:2];
  assign unused_addr = ^{address[REGISTER_LEN-1:SRAM_ADDR_WIDTH+1],
                         address[1:0]};
  assign req = rd_en | wr_en;
  assign cnt_nx = cnt_q + CW'(1);

  assign sram_dq = dq_oe_q ? dq_out_q : {SRAM_DATA_LEN{1'bz}};

  assign ready = (state_q == DONE) |
                 ((state_q == IDLE) & ~rd_en & ~wr_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
      read_data <= '0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q   <= LO;
            cnt_q     <= '0;
            wr_q      <= wr_en;
            idx_q     <= idx_in;
            wdata_q   <= write_data;
            sram_addr <= {idx_in, 1'b0};
            sram_ce_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            sram_oe_n <= wr_en;
            sram_we_n <= ~wr_en;
            dq_oe_q   <= wr_en;
            dq_out_q  <= write_data[15:0];
          end
        end
        LO, HI: begin
          if (cnt_q == CMAX) begin
            cnt_q <= '0;
            if (!wr_q) begin
              if (state_q == LO) read_data[15:0] <= sram_dq;
              else read_data[31:16] <= sram_dq;
            end
            if (state_q == LO) begin
              state_q   <= HI;
              sram_addr <= {idx_q, 1'b1};
              sram_we_n <= ~wr_q;
              dq_out_q  <= wdata_q[31:16];
            end else begin
              state_q   <= DONE;
              sram_we_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_ce_n <= 1'b1;
              sram_ub_n <= 1'b1;
              sram_lb_n <= 1'b1;
              dq_oe_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_nx;
            // WE rises one cycle before the address moves on
            sram_we_n <= ~wr_q | (cnt_nx == CMAX);
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM.
// Released bus reads back as all ones through pull-ups.
module tb_sram_controller;

  localparam int WAIT = 1;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] mem [1024];

  sram_controller #(
    .WAIT_CYCLES(WAIT),
    .SRAM_ADDR_WIDTH(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_dq(sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (sram_dq[g]);
  end

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ?
                   mem[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n)
      mem[sram_addr[9:0]] <= sram_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rexp, input bit gap);
    logic [17:0] base;
    logic [15:0] half;
    base = {a[18:2], 1'b0};
    wr_en = w;
    rd_en = r;
    address = a;
    write_data = d;
    if (gap) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(ready), 32'd0);
    end
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c <= WAIT; c++) begin
        @(negedge clk);
        check_eq("addr", 32'(sram_addr), 32'(base + 18'(h)));
        check_eq("ce_n", 32'(sram_ce_n), 32'd0);
        check_eq("ublb", 32'({sram_ub_n, sram_lb_n}), 32'd0);
        check_eq("busy", 32'(ready), 32'd0);
        if (w) begin
          half = (h == 1) ? d[31:16] : d[15:0];
          check_eq("dq_wr", 32'(sram_dq), 32'(half));
          check_eq("we_n", 32'(sram_we_n), (c == WAIT) ? 32'd1 : 32'd0);
          check_eq("oe_n_wr", 32'(sram_oe_n), 32'd1);
        end else begin
          check_eq("oe_n_rd", 32'(sram_oe_n), 32'd0);
          check_eq("we_n_rd", 32'(sram_we_n), 32'd1);
        end
      end
    end
    @(negedge clk);
    check_eq("done_rdy", 32'(ready), 32'd1);
    check_eq("done_ce", 32'(sram_ce_n), 32'd1);
    if (!w) check_eq("rdata", read_data, rexp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[2] = 16'h1234;
    mem[3] = 16'h5678;
    mem[8] = 16'h1111;
    mem[9] = 16'h2222;
    rst = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", 32'(ready), 32'd1);
    check_eq("rst_strb", 32'({sram_we_n, sram_oe_n, sram_ce_n,
                              sram_ub_n, sram_lb_n}), 32'h1F);
    check_eq("rst_dq", 32'(sram_dq), 32'h0000FFFF);
    check_eq("rst_rd", read_data, 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_rdy", 32'(ready), 32'd1);
    check_eq("idle_ce", 32'(sram_ce_n), 32'd1);

    access(1'b1, 1'b0, 32'h408, 32'hDEADBEEF, 32'd0, 1'b0);
    wr_en = 1'b0;
    check_eq("mem_lo", 32'(mem[10'h204]), 32'h0000BEEF);
    check_eq("mem_hi", 32'(mem[10'h205]), 32'h0000DEAD);
    @(negedge clk);
    check_eq("idle2", 32'(ready), 32'd1);

    access(1'b0, 1'b1, 32'h408, 32'd0, 32'hDEADBEEF, 1'b0);
    rd_en = 1'b0;
    @(negedge clk);
    check_eq("hold_rd", read_data, 32'hDEADBEEF);

    access(1'b1, 1'b0, 32'h0, 32'h0BADF00D, 32'd0, 1'b0);
    access(1'b0, 1'b1, 32'h4, 32'd0, 32'h56781234, 1'b1);
    rd_en = 1'b0;
    check_eq("b2b_mem0", 32'(mem[0]), 32'h0000F00D);
    check_eq("b2b_mem1", 32'(mem[1]), 32'h00000BAD);
    @(negedge clk);

    wr_en = 1'b1;
    address = 32'h10;
    write_data = 32'hAAAA5555;
    repeat (3) @(negedge clk);
    check_eq("mid_we", 32'(sram_we_n), 32'd0);
    check_eq("mid_addr", 32'(sram_addr), 32'd9);
    rst = 1'b0;
    wr_en = 1'b0;
    #1;
    check_eq("rmid_we", 32'(sram_we_n), 32'd1);
    check_eq("rmid_dq", 32'(sram_dq), 32'h0000FFFF);
    check_eq("rmid_rdy", 32'(ready), 32'd1);
    check_eq("rmid_ce", 32'(sram_ce_n), 32'd1);
    check_eq("rmid_rd", read_data, 32'd0);
    @(negedge clk);
    check_eq("rmid_idle", 32'(ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 32'h10, 32'd0, 32'h22225555, 1'b0);
    rd_en = 1'b0;
    @(negedge clk);

    access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq("both_keep", read_data, 32'h22225555);
    @(negedge clk);
    access(1'b0, 1'b1, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);
    rd_en = 1'b0;
    @(negedge clk);
    check_eq("end_idle", 32'(ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences 32-bit load/store requests from the MEM stage onto a 16-bit asynchronous external SRAM. Each word access is split into a low-half and a high-half SRAM cycle with configurable wait states. `ready` stalls the pipeline until the access completes. The block sits between the MEM stage's request signals and the board SRAM pins, replacing the single-cycle data memory.

## Interface
- `WAIT_CYCLES`, 1: extra cycles held per half-access; legal range ≥ 1.
- `SRAM_ADDR_WIDTH`, 18: SRAM half-word address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset; asynchronous, active-low.
- `rd_en` in 1: load request; held by the requester until `ready`.
- `wr_en` in 1: store request; held until `ready`.
- `address` in 32: byte address; `address[1:0]` ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load result; reset 0.
- `ready` out 1: 1 when no request is pending or the current access is complete.
- `sram_dq` inout 16: SRAM data bus; high-Z except while writing.
- `sram_addr` out `SRAM_ADDR_WIDTH`: half-word address; reset 0.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM strobes; all reset 1.

## Operation
- **Word index mapping:** `idx = address[SRAM_ADDR_WIDTH:2]`.
  - Low half lives at `{idx,1'b0}`, bits [15:0].
  - High half lives at `{idx,1'b1}`, bits [31:16].
- **FSM states:** IDLE, LO, HI, DONE.
- **IDLE:**
  - If `wr_en` or `rd_en` is set, latch op, `idx` and `write_data`, clear the wait counter, and go to LO.
  - If both are set, the op is a write.
- **LO / HI:**
  - Each state lasts `WAIT_CYCLES+1` cycles, tracked by a wait counter.
  - In the final cycle (counter == `WAIT_CYCLES`), clear the counter and advance LO→HI→DONE.
  - Strobes: `ce_n=0`, `ub_n=0`, `lb_n=0`, and `sram_addr` is set to the half address.
- **Read:**
  - `oe_n=0` and `dq` is high-Z.
  - At the final-cycle edge of LO, capture `dq` into `read_data[15:0]`; in HI, capture into `read_data[31:16]`.
- **Write:**
  - `dq` drives the latched half.
  - `we_n=0` in every cycle of the half except the final one, where `we_n=1`. This puts the WE rising edge before the address changes.
- **DONE:**
  - `ready=1` for exactly one cycle, with strobes inactive.
  - Unconditionally return to IDLE.
- **`ready` logic (combinational):** `ready = (state==DONE) | (state==IDLE & !rd_en & !wr_en)`.
- **Request dropped mid-access:** the latched access completes regardless, then the FSM returns to IDLE.
- **Reset, including mid-access:**
  - FSM goes to IDLE, counter clears, `read_data` becomes 0.
  - All strobes go to 1 and `dq` is released.
  - A partially written word in the SRAM is left as-is.
- **`read_data`:** holds its last value between loads; stores do not modify it.

## Timing
- A request sampled in IDLE at edge 0 produces DONE after `1 + 2*(WAIT_CYCLES+1)` edges. With `WAIT_CYCLES=1`, `ready` rises in cycle 5.
- Total occupancy is `2*WAIT_CYCLES+4` cycles per access, counting IDLE and DONE.
- `read_data` is valid in DONE, in the same cycle as `ready=1`.
- **Back-to-back requests:** the next request is taken in the IDLE cycle that follows DONE. There is no extra bubble.
- All outputs except `ready` and `sram_dq` come from registers; strobes are registered from the next state so they stay glitch-free.

## Structure
- **Shared package `sram_defs`:**
  - State encoding (2-bit localparams IDLE=0, LO=1, HI=2, DONE=3).
  - `SRAM_DATA_LEN`=16 and the default `SRAM_ADDR_WIDTH`, alongside the existing `REGISTER_LEN`.
- **Single module:** the wait counter and tri-state driver are inline, and no sub-module is needed.

## Test plan
- **Idle after reset:** release `rst` with no request → `ready=1`, all strobes 1, `dq` high-Z, `read_data=0`.
- **Store:** `wr_en=1`, `address=0x408`, `write_data=0xDEADBEEF`, `WAIT_CYCLES=1`.
  - Low half: `sram_addr=0x204` with `dq=0xBEEF` for 2 cycles.
  - High half: `sram_addr=0x205` with `dq=0xDEAD` for 2 cycles.
  - `we_n` pattern within each half is 0 then 1.
  - `ready` rises in cycle 5.
- **Load of the same address:** SRAM model preloaded → `read_data=0xDEADBEEF` with `ready=1` in cycle 5, and `oe_n=0` throughout LO/HI.
- **Back-to-back:** store at `0x0` followed immediately by a load at `0x4` → second access starts the cycle after DONE, with `sram_addr` 0x2 then 0x3.
- **Reset mid-write:** assert `rst` during HI → next sample shows IDLE, `we_n=1`, `dq` high-Z, `ready=1`. A later load at that address returns the new low half and the old high half.
- **Both enables set:** `rd_en=wr_en=1` → access runs as a write, and `oe_n` stays 1.
